// File: rtl/ccip_chan_buffer.sv
// ccip_chan_buffer
//   Single-clock buffer for one CCI-P channel direction. The entry width, the
//   depth and the almost-full slack are parameters. The output stage is
//   registered, and the block keeps debug statistics.
//
// Ports
//   afu_clk        sole clock
//   afu_softreset  asynchronous active-high reset
//   up_valid/up_data    producer push (a push into a full buffer is dropped)
//   up_almfull     registered back-pressure to the producer
//   dn_almfull     consumer back-pressure; used combinationally to gate the pop
//   dn_valid/dn_data    registered pop; dn_data is zero whenever dn_valid is 0
//   clr_stats      synchronous clear of hwm/overflow/drop_cnt
//   count          current occupancy
//   hwm            high-watermark of occupancy
//   overflow       sticky flag, set when a push is dropped
//   drop_cnt       number of dropped pushes, saturating
module ccip_chan_buffer #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 64,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                       afu_clk,
  input  logic                       afu_softreset,
  input  logic                       up_valid,
  input  logic [WIDTH-1:0]           up_data,
  output logic                       up_almfull,
  input  logic                       dn_almfull,
  output logic                       dn_valid,
  output logic [WIDTH-1:0]           dn_data,
  input  logic                       clr_stats,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     hwm,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] THR_C  = CW'(DEPTH - ALMFULL_SLACK);

  // Reject illegal configurations at elaboration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ccip_chan_buffer: DEPTH must be a power of 2 and at least 4");
  end
  if (ALMFULL_SLACK < 1 || ALMFULL_SLACK > DEPTH - 1) begin : g_bad_slack
    $error("ccip_chan_buffer: ALMFULL_SLACK must be in 1..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    hwm_q, hwm_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             up_almfull_q, up_almfull_d;
  logic             dn_valid_q, dn_valid_d;
  logic [WIDTH-1:0] dn_data_q, dn_data_d;

  logic push, drop, pop;

  // Fullness is judged on the occupancy at the start of the cycle, so a
  // pop in the same cycle does not make room for the push.
  assign push = up_valid & (count_q != FULL_C);
  assign drop = up_valid & (count_q == FULL_C);
  assign pop  = (count_q != '0) & ~dn_almfull;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hwm_d        = hwm_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    up_almfull_d = up_almfull_q;
    dn_valid_d   = pop;
    dn_data_d    = '0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      dn_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    up_almfull_d = (count_d >= THR_C);

    // A clear restarts the watermark from the new occupancy rather than
    // from zero, so hwm never reads below count.
    if (clr_stats)            hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;

    // A drop in the same cycle as a clear wins. The first drop after the clear is counted.
    if (clr_stats) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge afu_clk) begin
    if (push) mem_q[wr_ptr_q] <= up_data;
  end

  always_ff @(posedge afu_clk or posedge afu_softreset) begin
    if (afu_softreset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hwm_q        <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      up_almfull_q <= 1'b0;
      dn_valid_q   <= 1'b0;
      dn_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hwm_q        <= hwm_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      up_almfull_q <= up_almfull_d;
      dn_valid_q   <= dn_valid_d;
      dn_data_q    <= dn_data_d;
    end
  end

  assign up_almfull = up_almfull_q;
  assign dn_valid   = dn_valid_q;
  assign dn_data    = dn_data_q;
  assign count      = count_q;
  assign hwm        = hwm_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
